raw_stream_tx: RTL

Raw-domain pixel stream transmitter: pulls pixels from an upstream ready/valid source (frame buffer reader / DMA) and emits the timed raster stream (`pix_o`, `valid_o`, `line_sync_o`, `frame_sync_o`) consumed by the NLM denoise pipeline's input side.
- Inserts programmable horizontal and vertical blanking.
- Marks frame and line starts with single-cycle sync pulses.
- Reports mid-line starvation of the upstream source.

---
 rtl/raw_stream_tx.sv | 137 +++++++++++++
 1 files changed

// File: rtl/raw_stream_tx.sv
// Raw-domain raster transmitter: pulls pixels from a ready/valid source and emits
// a timed stream with programmable horizontal/vertical blanking and sync pulses.
module raw_stream_tx #(
  parameter int IMAGE_WIDTH  = 1920,
  parameter int IMAGE_HEIGHT = 1080,
  parameter int DATA_WIDTH   = 12,
  parameter int ADDR_WIDTH   = 12,
  parameter int HBLANK       = 280,
  parameter int VBLANK       = 45
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en_i,
  input  logic                  clr_err_i,
  input  logic                  in_valid_i,
  input  logic [DATA_WIDTH-1:0] in_pix_i,
  output logic                  in_ready_o,
  output logic [DATA_WIDTH-1:0] pix_o,
  output logic                  valid_o,
  output logic                  line_sync_o,
  output logic                  frame_sync_o,
  output logic                  busy_o,
  output logic                  frame_done_o,
  output logic                  underflow_o,
  output logic [1:0]            dbg_state
);

  // Upstream handshake: a pixel moves when in_valid_i and in_ready_o are both
  // high on a rising edge; in_ready_o depends on state only, never on in_valid_i.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_VBLANK = 2'd1,
    S_ACTIVE = 2'd2,
    S_HBLANK = 2'd3
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] X_LAST  = ADDR_WIDTH'(IMAGE_WIDTH - 1);
  localparam logic [ADDR_WIDTH-1:0] Y_LAST  = ADDR_WIDTH'(IMAGE_HEIGHT - 1);
  localparam logic [ADDR_WIDTH-1:0] HB_LAST = ADDR_WIDTH'(HBLANK - 1);
  localparam logic [ADDR_WIDTH-1:0] VB_LAST = ADDR_WIDTH'(VBLANK - 1);

  state_t                state;
  state_t                state_nxt;
  logic [ADDR_WIDTH-1:0] x;
  logic [ADDR_WIDTH-1:0] y;
  logic [ADDR_WIDTH-1:0] b;
  logic                  accept;
  logic                  line_end;
  logic                  frame_end;
  logic                  starve;

  assign accept    = in_valid_i & in_ready_o;
  assign line_end  = accept & (x == X_LAST);
  assign frame_end = line_end & (y == Y_LAST);
  // Starving at column 0 is a legal line-start slip; only mid-line gaps flag.
  assign starve    = (state == S_ACTIVE) & ~in_valid_i & (x != '0);
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (en_i) state_nxt = S_VBLANK;
      S_VBLANK: if (b == VB_LAST) state_nxt = S_ACTIVE;
      S_ACTIVE: begin
        if (frame_end)     state_nxt = en_i ? S_VBLANK : S_IDLE;
        else if (line_end) state_nxt = S_HBLANK;
      end
      S_HBLANK: if (b == HB_LAST) state_nxt = S_ACTIVE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready_o = (state == S_ACTIVE);
    busy_o     = (state != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x <= '0;
      y <= '0;
      b <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (en_i) begin
            x <= '0;
            y <= '0;
            b <= '0;
          end
        end
        S_VBLANK, S_HBLANK: b <= b + 1'b1;
        S_ACTIVE: begin
          if (accept) begin
            if (line_end) begin
              x <= '0;
              b <= '0;
              y <= (y == Y_LAST) ? '0 : y + 1'b1;
            end else begin
              x <= x + 1'b1;
            end
          end
        end
        default: b <= '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_o        <= '0;
      valid_o      <= 1'b0;
      line_sync_o  <= 1'b0;
      frame_sync_o <= 1'b0;
      frame_done_o <= 1'b0;
    end else begin
      valid_o      <= accept;
      line_sync_o  <= accept & (x == '0);
      frame_sync_o <= accept & (x == '0) & (y == '0);
      frame_done_o <= frame_end;
      if (accept) pix_o <= in_pix_i;
    end
  end

  // A new starvation event wins over a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         underflow_o <= 1'b0;
    else if (starve)    underflow_o <= 1'b1;
    else if (clr_err_i) underflow_o <= 1'b0;
  end

endmodule
